// File: rtl/alu_seq.sv
// alu_seq: handshaked ALU. Logic, arithmetic, compare and shift operations
// complete in one cycle; MUL/MULHU run an iterative shift-add multiply, one
// multiplier bit per cycle. The result and its flags are held registered
// until the consumer takes them.
module alu_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [3:0]       ctrl_i,
    input  logic [WIDTH-1:0] src1_i,
    input  logic [WIDTH-1:0] src2_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] result_o,
    output logic             zero_o,
    output logic             ovf_o,
    output logic             err_o
);

    localparam int SHW = $clog2(WIDTH);

    localparam logic [3:0] OP_AND   = 4'd0;
    localparam logic [3:0] OP_OR    = 4'd1;
    localparam logic [3:0] OP_ADD   = 4'd2;
    localparam logic [3:0] OP_SLTU  = 4'd3;
    localparam logic [3:0] OP_SLT   = 4'd4;
    localparam logic [3:0] OP_XOR   = 4'd5;
    localparam logic [3:0] OP_SUB   = 4'd6;
    localparam logic [3:0] OP_EQ    = 4'd7;
    localparam logic [3:0] OP_SRA   = 4'd8;
    localparam logic [3:0] OP_SRL   = 4'd9;
    localparam logic [3:0] OP_SLL   = 4'd10;
    localparam logic [3:0] OP_LUI   = 4'd11;
    localparam logic [3:0] OP_MUL   = 4'd12;
    localparam logic [3:0] OP_MULHU = 4'd13;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_t;

    state_t               r_state;
    logic [WIDTH-1:0]     r_result;
    logic                 r_zero;
    logic                 r_ovf;
    logic                 r_err;
    logic [2*WIDTH-1:0]   r_mcand;
    logic [WIDTH-1:0]     r_mplier;
    logic [2*WIDTH-1:0]   r_acc;
    logic [SHW-1:0]       r_cnt;
    logic                 r_mul_hi;

    logic [WIDTH-1:0]     w_sum;
    logic [WIDTH-1:0]     w_diff;
    logic [SHW-1:0]       w_shamt;
    logic [WIDTH-1:0]     w_alu_res;
    logic                 w_alu_ovf;
    logic                 w_alu_err;
    logic                 w_is_mul;
    logic [2*WIDTH-1:0]   w_addend;
    logic [2*WIDTH-1:0]   w_acc_next;
    logic [WIDTH-1:0]     w_mul_res;

    assign w_sum    = src1_i + src2_i;
    assign w_diff   = src1_i - src2_i;
    assign w_shamt  = src1_i[SHW-1:0];
    assign w_is_mul = (ctrl_i == OP_MUL) || (ctrl_i == OP_MULHU);

    // Single-cycle result and flags, computed from the live inputs so they
    // can be registered on the accept edge.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves a latch.
        w_alu_res = '0;
        w_alu_ovf = 1'b0;
        w_alu_err = 1'b0;
        case (ctrl_i)
            OP_AND:  w_alu_res = src1_i & src2_i;
            OP_OR:   w_alu_res = src1_i | src2_i;
            OP_ADD: begin
                w_alu_res = w_sum;
                w_alu_ovf = (src1_i[WIDTH-1] == src2_i[WIDTH-1]) &&
                            (w_sum[WIDTH-1] != src1_i[WIDTH-1]);
            end
            OP_SLTU: w_alu_res = WIDTH'(src1_i < src2_i);
            OP_SLT:  w_alu_res = WIDTH'($signed(src1_i) < $signed(src2_i));
            OP_XOR:  w_alu_res = src1_i ^ src2_i;
            OP_SUB: begin
                w_alu_res = w_diff;
                w_alu_ovf = (src1_i[WIDTH-1] != src2_i[WIDTH-1]) &&
                            (w_diff[WIDTH-1] != src1_i[WIDTH-1]);
            end
            OP_EQ:   w_alu_res = WIDTH'(src1_i == src2_i);
            OP_SRA:  w_alu_res = $signed(src2_i) >>> w_shamt;
            OP_SRL:  w_alu_res = src2_i >> w_shamt;
            OP_SLL:  w_alu_res = src2_i << w_shamt;
            OP_LUI:  w_alu_res = src2_i << (WIDTH / 2);
            OP_MUL, OP_MULHU: w_alu_res = '0;
            default: w_alu_err = 1'b1;
        endcase
    end

    // One shift-add step: add the multiplicand shifted by the current bit
    // position when that multiplier bit is set.
    always_comb begin
        w_addend   = r_mplier[r_cnt] ? (r_mcand << r_cnt) : '0;
        w_acc_next = r_acc + w_addend;
        w_mul_res  = r_mul_hi ? w_acc_next[2*WIDTH-1:WIDTH] : w_acc_next[WIDTH-1:0];
    end

    // Handshake FSM, multiply datapath and registered result/flags.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            // NOTE: the datapath registers are reset too, so a multiply cut
            // short by reset leaves no stale partial product behind.
            r_state  <= S_IDLE;
            r_result <= '0;
            r_zero   <= 1'b1;
            r_ovf    <= 1'b0;
            r_err    <= 1'b0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_mul_hi <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values regardless of statement order.
            case (r_state)
                S_IDLE: begin
                    if (in_valid_i) begin
                        if (w_is_mul) begin
                            r_mcand  <= {{WIDTH{1'b0}}, src1_i};
                            r_mplier <= src2_i;
                            r_acc    <= '0;
                            r_cnt    <= '0;
                            r_mul_hi <= (ctrl_i == OP_MULHU);
                            r_state  <= S_BUSY;
                        end else begin
                            r_result <= w_alu_res;
                            r_zero   <= (w_alu_res == '0);
                            r_ovf    <= w_alu_ovf;
                            r_err    <= w_alu_err;
                            r_state  <= S_DONE;
                        end
                    end
                end
                S_BUSY: begin
                    r_acc <= w_acc_next;
                    r_cnt <= r_cnt + SHW'(1);
                    if (r_cnt == SHW'(WIDTH - 1)) begin
                        r_result <= w_mul_res;
                        r_zero   <= (w_mul_res == '0);
                        r_ovf    <= 1'b0;
                        r_err    <= 1'b0;
                        r_state  <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready_i) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign in_ready_o  = (r_state == S_IDLE);
    assign out_valid_o = (r_state == S_DONE);
    assign result_o    = r_result;
    assign zero_o      = r_zero;
    assign ovf_o       = r_ovf;
    assign err_o       = r_err;

endmodule
